// File: rtl/ieee_pkg.sv
// ieee_pkg: shared bus type, state encoding and default timing constants for
// the IEEE-488 source/acceptor handshake controller.
package ieee_pkg;

   // One end's view of the GPIB lines; every line is active-low (1 = released).
   typedef struct packed {
      logic [7:0] data;
      logic       dav;
      logic       nrfd;
      logic       ndac;
      logic       eoi;
      logic       atn;
      logic       srq;
      logic       ren;
      logic       ifc;
   } st_ieee_bus;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_WAIT_RFD = 3'd2,
      ST_WAIT_DAC = 3'd3,
      ST_REL_DAV  = 3'd4,
      ST_LST_RDY  = 3'd5,
      ST_LST_HOLD = 3'd6,
      ST_LST_END  = 3'd7
   } ieee_state_e;

   localparam int SETTLE_DEF  = 4;
   localparam int TIMEOUT_DEF = 16384;

   // Every line released, including the data lines.
   localparam st_ieee_bus BUS_RELEASED = st_ieee_bus'(16'hFFFF);

   // Byte as it appears on the inverted-logic data lines (either direction).
   function automatic logic [7:0] bus_byte(input logic [7:0] b);
      return ~b;
   endfunction

endpackage

// File: rtl/ieee_sync.sv
// ieee_sync: two-flop resynchronizer for the wired-AND bus state. Resets to
// the released level so the controller never sees a phantom handshake.
module ieee_sync
   import ieee_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset,
   input  st_ieee_bus bus_i,
   output st_ieee_bus bus_o
);

   st_ieee_bus meta_q;
   st_ieee_bus sync_q;

   // two-stage capture of the asynchronous bus lines
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         meta_q <= BUS_RELEASED;
         sync_q <= BUS_RELEASED;
      end else begin
         meta_q <= bus_i;
         sync_q <= meta_q;
      end
   end

   assign bus_o = sync_q;

endmodule

// File: rtl/ieee_ctrl_hs.sv
// ieee_ctrl_hs: IEEE-488 three-wire handshake controller, talker (source) and
// listener (acceptor) roles. Optional wait-state watchdog is built only when
// macro IEEE_CTRL_TIMEOUT_EN is defined; otherwise wait states never expire.
module ieee_ctrl_hs
   import ieee_pkg::*;
#(
   parameter int SETTLE  = SETTLE_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ce,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_atn,
   input  logic       tx_eoi,
   input  logic       rx_en,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_eoi,
   input  st_ieee_bus bus_i,
   output st_ieee_bus bus_o,
   output logic       busy,
   output logic       err_nodev,
   output logic       err_timeout
);

   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   ieee_state_e      state_q;
   st_ieee_bus       bus_q;
   st_ieee_bus       sync_s;
   logic [SET_W-1:0] settle_q;
   logic             rx_valid_q;
   logic [7:0]       rx_data_q;
   logic             rx_eoi_q;
   logic             err_nodev_q;
   logic             tx_accept_s;
   logic             unused_bits_s;

`ifdef IEEE_CTRL_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TMO_W-1:0] tmo_q;
   logic             tmo_run_s;
   logic             err_tmo_q;
`else
   localparam int unused_timeout = TIMEOUT;
`endif

   ieee_sync u_sync (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus_i   (bus_i),
      .bus_o   (sync_s)
   );

   // The accept is gated with ce so a byte is never offered on a dead tick.
   assign tx_ready    = (state_q == ST_IDLE) && !reset && ce;
   assign tx_accept_s = tx_valid && tx_ready;
   assign unused_bits_s = ^{sync_s.atn, sync_s.srq, sync_s.ren, sync_s.ifc};

`ifdef IEEE_CTRL_TIMEOUT_EN
   // watchdog runs only while a wait state is still waiting on the bus
   always_comb begin
      tmo_run_s = 1'b0;
      case (state_q)
         ST_WAIT_RFD: tmo_run_s = !sync_s.nrfd;
         ST_WAIT_DAC: tmo_run_s = !sync_s.ndac;
         ST_LST_RDY:  tmo_run_s = !rx_en && sync_s.dav;
         ST_LST_END:  tmo_run_s = !sync_s.dav;
         default:     tmo_run_s = 1'b0;
      endcase
   end
`endif

   // handshake sequencer: state, line drive and status flags
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bus_q       <= BUS_RELEASED;
         settle_q    <= '0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_eoi_q    <= 1'b0;
         err_nodev_q <= 1'b0;
`ifdef IEEE_CTRL_TIMEOUT_EN
         tmo_q       <= '0;
         err_tmo_q   <= 1'b0;
`endif
      end else begin
         bus_q.srq <= 1'b1;
         bus_q.ren <= 1'b1;
         bus_q.ifc <= 1'b1;
         if (ce) begin
`ifdef IEEE_CTRL_TIMEOUT_EN
            // any tick that leaves the wait restarts the count
            tmo_q <= '0;
`endif
            case (state_q)
               ST_IDLE: begin
                  if (tx_accept_s) begin
                     bus_q.data  <= bus_byte(tx_data);
                     bus_q.eoi   <= ~(tx_eoi & ~tx_atn);
                     bus_q.atn   <= ~tx_atn;
                     err_nodev_q <= 1'b0;
`ifdef IEEE_CTRL_TIMEOUT_EN
                     err_tmo_q   <= 1'b0;
`endif
                     settle_q    <= '0;
                     state_q     <= ST_SETTLE;
                  end else if (rx_en) begin
                     bus_q.atn  <= 1'b1;
                     bus_q.nrfd <= 1'b1;
                     bus_q.ndac <= 1'b0;
                     state_q    <= ST_LST_RDY;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_SETTLE: begin
                  if (settle_q == SET_W'(SETTLE - 1)) begin
                     state_q <= ST_WAIT_RFD;
                  end else begin
                     settle_q <= settle_q + SET_W'(1);
                  end
               end
               ST_WAIT_RFD: begin
                  if (sync_s.nrfd && sync_s.ndac) begin
                     // nobody pulls NDAC: no acceptor on the bus
                     err_nodev_q <= 1'b1;
                     bus_q       <= BUS_RELEASED;
                     state_q     <= ST_IDLE;
                  end else if (sync_s.nrfd) begin
                     bus_q.dav <= 1'b0;
                     state_q   <= ST_WAIT_DAC;
                  end else begin
                     state_q <= ST_WAIT_RFD;
                  end
               end
               ST_WAIT_DAC: begin
                  if (sync_s.ndac) begin
                     bus_q.dav  <= 1'b1;
                     bus_q.data <= 8'hFF;
                     bus_q.eoi  <= 1'b1;
                     state_q    <= ST_REL_DAV;
                  end else begin
                     state_q <= ST_WAIT_DAC;
                  end
               end
               ST_REL_DAV: begin
                  state_q <= ST_IDLE;
               end
               ST_LST_RDY: begin
                  if (!sync_s.dav) begin
                     rx_data_q  <= bus_byte(sync_s.data);
                     rx_eoi_q   <= ~sync_s.eoi;
                     bus_q.nrfd <= 1'b0;
                     rx_valid_q <= 1'b1;
                     state_q    <= ST_LST_HOLD;
                  end else begin
                     state_q <= ST_LST_RDY;
                  end
               end
               ST_LST_HOLD: begin
                  if (rx_valid_q && rx_ready) begin
                     rx_valid_q <= 1'b0;
                     bus_q.ndac <= 1'b1;
                     state_q    <= ST_LST_END;
                  end else begin
                     state_q <= ST_LST_HOLD;
                  end
               end
               ST_LST_END: begin
                  if (sync_s.dav && rx_en) begin
                     bus_q.ndac <= 1'b0;
                     bus_q.nrfd <= 1'b1;
                     state_q    <= ST_LST_RDY;
                  end else if (sync_s.dav) begin
                     // leaving listen: stop holding NDAC so our own drive
                     // cannot fake an acceptor on a later talk cycle
                     bus_q.ndac <= 1'b1;
                     bus_q.nrfd <= 1'b1;
                     state_q    <= ST_IDLE;
                  end else begin
                     state_q <= ST_LST_END;
                  end
               end
               default: begin
                  bus_q   <= BUS_RELEASED;
                  state_q <= ST_IDLE;
               end
            endcase
`ifdef IEEE_CTRL_TIMEOUT_EN
            // expiry overrides the stay decision made above
            if (tmo_run_s) begin
               if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  err_tmo_q <= 1'b1;
                  bus_q     <= BUS_RELEASED;
                  state_q   <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
`endif
         end
      end
   end

   assign bus_o     = bus_q;
   assign busy      = (state_q != ST_IDLE);
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign rx_eoi    = rx_eoi_q;
   assign err_nodev = err_nodev_q;
`ifdef IEEE_CTRL_TIMEOUT_EN
   assign err_timeout = err_tmo_q;
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ieee_ctrl_hs.sv
// tb_ieee_ctrl_hs: directed bench for ieee_ctrl_hs. The far end of the bus is
// a hand-driven device (ext_s) wired-ANDed with the controller's drive.
`timescale 1ns/1ps
module tb_ieee_ctrl_hs;
   import ieee_pkg::*;

   logic       clk_sys = 1'b0;
   logic       reset, ce;
   logic       tx_valid, tx_atn, tx_eoi, rx_en, rx_ready;
   logic [7:0] tx_data;
   logic       tx_ready, rx_valid, rx_eoi, busy, err_nodev, err_timeout;
   logic [7:0] rx_data;
   st_ieee_bus bus_o_s, ext_s, bus_i_s;

   int n_checks = 0;
   int n_fail   = 0;
   int n;

   assign bus_i_s = bus_o_s & ext_s;

   always #5 clk_sys = ~clk_sys;

   ieee_ctrl_hs #(.SETTLE(4), .TIMEOUT(16)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ce          (ce),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .tx_atn      (tx_atn),
      .tx_eoi      (tx_eoi),
      .rx_en       (rx_en),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_data     (rx_data),
      .rx_eoi      (rx_eoi),
      .bus_i       (bus_i_s),
      .bus_o       (bus_o_s),
      .busy        (busy),
      .err_nodev   (err_nodev),
      .err_timeout (err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return bus_o_s.dav;
         1:       return busy;
         2:       return rx_valid;
         default: return 1'b0;
      endcase
   endfunction

   // wait (bounded) until the selected output reaches val; n = ticks taken
   task automatic wait_for(input int sel, input logic val, input int bound,
                           input string tag, output int cnt);
      cnt = 0;
      while (sig(sel) !== val && cnt < bound) begin
         tick();
         cnt++;
      end
      chk(tag, 32'(sig(sel)), 32'(val));
   endtask

   task automatic send(input logic [7:0] d, input logic a, input logic e);
      tx_data  = d;
      tx_atn   = a;
      tx_eoi   = e;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
   endtask

   // acceptor present and ready: NRFD released, NDAC held low
   task automatic ext_ready();
      ext_s      = BUS_RELEASED;
      ext_s.ndac = 1'b0;
   endtask

   // acceptor has taken the byte: NRFD low, NDAC released
   task automatic ext_accepted();
      ext_s.nrfd = 1'b0;
      ext_s.ndac = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ce = 1'b1; tx_valid = 1'b0; tx_atn = 1'b0; tx_eoi = 1'b0;
      tx_data = 8'h00; rx_en = 1'b0; rx_ready = 1'b0;
      ext_ready();
      tick(); tick();
      chk("rst_bus", 32'(bus_o_s), 32'h0000_FFFF);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      reset = 1'b0;
      tick(); tick();
      chk("idle_tx_ready", 32'(tx_ready), 32'd1);
      chk("idle_errs", 32'({err_nodev, err_timeout, rx_valid, rx_eoi}), 32'd0);

      // single command byte 3F with ATN
      send(8'h3F, 1'b1, 1'b0);
      chk("t1_data", 32'(bus_o_s.data), 32'h0000_00C0);
      chk("t1_atn", 32'(bus_o_s.atn), 32'd0);
      chk("t1_eoi", 32'(bus_o_s.eoi), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      wait_for(0, 1'b0, 20, "t1_dav_low", n);
      chk("t1_settle_ticks", 32'(n), 32'd5);
      ext_accepted();
      wait_for(0, 1'b1, 10, "t1_dav_rel", n);
      chk("t1_data_rel", 32'(bus_o_s.data), 32'h0000_00FF);
      chk("t1_rel_busy", 32'(busy), 32'd1);
      tick();
      chk("t1_idle", 32'(busy), 32'd0);
      chk("t1_atn_hold", 32'(bus_o_s.atn), 32'd0);
      ext_ready();
      tick(); tick(); tick();

      // data byte 41 with EOI, ATN released
      send(8'h41, 1'b0, 1'b1);
      chk("t3_atn_rel", 32'(bus_o_s.atn), 32'd1);
      wait_for(0, 1'b0, 20, "t3_dav_low", n);
      chk("t3_data", 32'(bus_o_s.data), 32'h0000_00BE);
      chk("t3_eoi", 32'(bus_o_s.eoi), 32'd0);
      ext_accepted();
      wait_for(0, 1'b1, 10, "t3_dav_rel", n);
      chk("t3_eoi_rel", 32'(bus_o_s.eoi), 32'd1);
      wait_for(1, 1'b0, 5, "t3_idle", n);

      // no device: NRFD and NDAC both released
      ext_s = BUS_RELEASED;
      tick(); tick(); tick();
      send(8'h55, 1'b0, 1'b0);
      wait_for(1, 1'b0, 30, "t2_idle", n);
      chk("t2_nodev", 32'(err_nodev), 32'd1);
      chk("t2_bus", 32'(bus_o_s), 32'h0000_FFFF);
      chk("t2_tx_ready", 32'(tx_ready), 32'd1);

      // listen: talker sends AA (bus 55) with EOI low
      rx_en = 1'b1;
      tick();
      chk("t4_busy", 32'(busy), 32'd1);
      chk("t4_lines", 32'({bus_o_s.nrfd, bus_o_s.ndac}), 32'd2);
      ext_s.data = 8'h55; ext_s.eoi = 1'b0; ext_s.dav = 1'b0;
      wait_for(2, 1'b1, 10, "t4_rx_valid", n);
      chk("t4_rx_data", 32'(rx_data), 32'h0000_00AA);
      chk("t4_rx_eoi", 32'(rx_eoi), 32'd1);
      tick(); tick(); tick();
      chk("t4_hold", 32'({rx_valid, bus_o_s.nrfd, bus_o_s.ndac}), 32'd4);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      rx_en = 1'b0;
      chk("t4_done", 32'({rx_valid, bus_o_s.nrfd, bus_o_s.ndac}), 32'd1);
      ext_s = BUS_RELEASED;
      wait_for(1, 1'b0, 10, "t4_idle", n);
      chk("t4_bus", 32'(bus_o_s), 32'h0000_FFFF);
      chk("t4_nodev_sticky", 32'(err_nodev), 32'd1);

      // acceptor stuck with NDAC low in WAIT_DAC
      ext_ready();
      tick(); tick(); tick();
      send(8'h12, 1'b0, 1'b0);
      chk("t5_nodev_clr", 32'(err_nodev), 32'd0);
      wait_for(0, 1'b0, 20, "t5_dav_low", n);
`ifdef IEEE_CTRL_TIMEOUT_EN
      wait_for(1, 1'b0, 40, "t5_tmo_idle", n);
      chk("t5_tmo_ticks", 32'(n), 32'd16);
      chk("t5_tmo_flag", 32'(err_timeout), 32'd1);
      chk("t5_tmo_bus", 32'(bus_o_s), 32'h0000_FFFF);
`else
      for (int i = 0; i < 40; i++) tick();
      chk("t5_still_busy", 32'(busy), 32'd1);
      chk("t5_still_dav", 32'(bus_o_s.dav), 32'd0);
      chk("t5_no_tmo", 32'(err_timeout), 32'd0);
      ext_accepted();
      wait_for(1, 1'b0, 20, "t5_idle", n);
`endif
      ext_ready();
      tick(); tick(); tick();

      // reset in WAIT_DAC with ce low
      send(8'h99, 1'b1, 1'b0);
      chk("t6_tmo_clr", 32'(err_timeout), 32'd0);
      wait_for(0, 1'b0, 20, "t6_dav_low", n);
      ce = 1'b0;
      ext_accepted();
      for (int i = 0; i < 6; i++) tick();
      chk("t6_ce_freeze", 32'({busy, bus_o_s.dav}), 32'd2);
      reset = 1'b1;
      tick();
      chk("t6_rst_bus", 32'(bus_o_s), 32'h0000_FFFF);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_tx_ready", 32'(tx_ready), 32'd0);
      reset = 1'b0;
      ce = 1'b1;
      ext_ready();
      tick();
      chk("t6_tx_ready", 32'(tx_ready), 32'd1);
      chk("t6_rx_data", 32'(rx_data), 32'd0);
      chk("t6_errs", 32'({err_nodev, err_timeout}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
